// File: rtl/sw_debounce.sv
// sw_debounce: two-flop synchronizer plus per-channel stability counter for
// the slide switches. A channel's clean level follows its synchronized input
// only after DEBOUNCE_CYCLES consecutive mismatching clocks.
// Optional registered rise/fall/any-edge pulses: define SW_DEBOUNCE_EDGE_EN.
// Without it the pulse outputs are tied to 0 and sw_clean is unchanged.

// One switch channel: synchronizer, stability counter and clean level.
module sw_debounce_lane #(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int CW              = $clog2(DEBOUNCE_CYCLES)
) (
  input  logic clk,
  input  logic rst,
  input  logic sw,
  output logic clean,
  output logic accept
);
  typedef enum logic {STABLE = 1'b0, PENDING = 1'b1} lane_st_t;

  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1, sync2;
  logic [CW-1:0] cnt;
  lane_st_t      st;

  // Channel state is implied by whether the synchronized input agrees with clean.
  always_comb begin
    st     = (sync2 != clean) ? PENDING : STABLE;
    accept = (st == PENDING) && (cnt == LAST);
  end

  // Synchronize, count consecutive mismatches, accept the new level at threshold.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      clean <= 1'b0;
      cnt   <= '0;
    end else begin
      sync1 <= sw;
      sync2 <= sync1;
      if (st == STABLE) begin
        cnt <= '0;
      end else if (accept) begin
        clean <= sync2;
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end
endmodule

module sw_debounce #(
  parameter int N               = 16,
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int CW              = $clog2(DEBOUNCE_CYCLES)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] SW,
  output logic [N-1:0] sw_clean,
  output logic [N-1:0] sw_rise,
  output logic [N-1:0] sw_fall,
  output logic         sw_any_edge
);
  // accept[i] is high on the cycle whose edge moves sw_clean[i]; it depends
  // only on lane registers, never on SW directly.
  logic [N-1:0] accept;

  for (genvar i = 0; i < N; i++) begin : g_lane
    sw_debounce_lane #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .CW              (CW)
    ) u_lane (
      .clk    (clk),
      .rst    (rst),
      .sw     (SW[i]),
      .clean  (sw_clean[i]),
      .accept (accept[i])
    );
  end

`ifdef SW_DEBOUNCE_EDGE_EN
  // Register pulses on the same edge that updates sw_clean; the direction is
  // the inverse of the level being replaced.
  always_ff @(posedge clk) begin
    if (rst) begin
      sw_rise     <= '0;
      sw_fall     <= '0;
      sw_any_edge <= 1'b0;
    end else begin
      sw_rise     <= accept & ~sw_clean;
      sw_fall     <= accept &  sw_clean;
      sw_any_edge <= |accept;
    end
  end
`else
  logic unused_accept;
  assign unused_accept = |accept;
  assign sw_rise       = '0;
  assign sw_fall       = '0;
  assign sw_any_edge   = 1'b0;
`endif
endmodule

// File: doc/sw_debounce.md
# sw_debounce

Conditions the raw slide-switch inputs on the Nexys A7 board before they reach the comparator and LED logic. Each of the N channels passes through a two-flop synchronizer and a per-channel stability counter. A channel's clean output changes only after its synchronized input has disagreed with the clean value for DEBOUNCE_CYCLES consecutive clocks. Optional one-cycle rise and fall pulses are provided for downstream event-driven logic such as counters and FSMs.

## Interface
- N, default 16: number of switch channels.
- DEBOUNCE_CYCLES, default 1_000_000: consecutive mismatching cycles required to accept a change. At 100 MHz this is 10 ms. Minimum legal value is 2.
- CW, default $clog2(DEBOUNCE_CYCLES): width of each channel's counter. Derived; do not override.
- clk, input, 1: 100 MHz system clock. All state updates on the rising edge.
- rst, input, 1: synchronous, active-high reset.
- SW, input, N: raw asynchronous switch levels.
- sw_clean, output, N: debounced level, one bit per channel.
- sw_rise, output, N: one-cycle pulse when sw_clean goes 0→1.
- sw_fall, output, N: one-cycle pulse when sw_clean goes 1→0.
- sw_any_edge, output, 1: OR-reduction of sw_rise | sw_fall.

## Operation
- Per channel i, the state is: sync1[i], sync2[i], clean[i], cnt_i[CW-1:0].
- Synchronizer: sync1 <= SW; sync2 <= sync1. No combinational use of SW anywhere in the block.
- Two-state behaviour per channel: STABLE (sync2 == clean) and PENDING (sync2 != clean).
- In STABLE: cnt <= 0.
- In PENDING with cnt < DEBOUNCE_CYCLES-1: cnt <= cnt + 1.
- In PENDING with cnt == DEBOUNCE_CYCLES-1: clean <= sync2 and cnt <= 0, on the same edge. The edge pulse is registered on that same edge.
- Glitch rule: if sync2 returns to clean before the threshold is reached, the channel is back in STABLE, cnt clears to 0, and clean never moves.
- The counter never wraps. It is bounded by the threshold compare.
- Channels are fully independent. Simultaneous changes on several channels are each handled separately and may pulse on the same cycle.
- Reset clears sync1, sync2, clean, cnt, sw_rise, sw_fall and sw_any_edge to 0.
- Reset in the middle of a count discards the count.
- A switch held high through reset produces a normal rise (with sw_rise pulse) after the full latency once rst deasserts.
- rst takes priority over every other update.

## Timing
- All outputs are registered. No combinational path from SW to any output.
- Latency: SW stable from edge k → sync2 valid at edge k+2 → sw_clean changes at edge k+2+DEBOUNCE_CYCLES.
- sw_rise[i] / sw_fall[i] are high for exactly the one cycle during which sw_clean[i] shows its new value. They are 0 on all other cycles.
- sw_any_edge is registered and aligned with sw_rise / sw_fall.
- Glitch rejection: any input pulse shorter than DEBOUNCE_CYCLES cycles, measured at sync2, is fully rejected.
- Reset values of all outputs: 0.

## Configuration
- Macro: SW_DEBOUNCE_EDGE_EN.
- Defined: the sw_rise, sw_fall and sw_any_edge registers are generated as described above.
- Undefined:
  - The edge-pulse registers are not built.
  - sw_rise, sw_fall and sw_any_edge are tied to constant 0.
  - The ports remain present, so instantiations are unchanged.
  - sw_clean behaviour is identical in both builds.

## Test plan
All scenarios use DEBOUNCE_CYCLES=4, N=16, with SW changed just after a clock edge.
- **Reset:** hold rst=1 for 3 cycles with SW=16'hFFFF → all outputs 0 during reset. After release, sw_clean=16'hFFFF 6 edges later, with sw_rise=16'hFFFF and sw_any_edge=1 for exactly 1 cycle.
- **Clean rise:** SW[0] 0→1 and held → sw_clean[0]=1 at edge +6, sw_rise[0] pulses 1 cycle, sw_fall stays 0, other channels unchanged.
- **Glitch rejection:** SW[3] high for 3 cycles then low → sw_clean[3] stays 0 and no pulses. Repeat with 4 cycles high → sw_clean[3] rises.
- **Bounce:** SW[5] toggles 1,0,1,0,1 every cycle then holds 1 → sw_clean[5] rises only 6 edges after the final hold begins, with a single sw_rise pulse.
- **Simultaneous channels:** SW[1] 0→1 and SW[2] 1→0 on the same cycle → sw_rise[1] and sw_fall[2] pulse on the same cycle, and sw_any_edge=1 for one cycle.
- **Reset mid-count and macro off:** assert rst 2 cycles into PENDING → count discarded and the full latency restarts after release. With SW_DEBOUNCE_EDGE_EN undefined, rerun the clean-rise scenario → sw_clean identical, and sw_rise/sw_fall/sw_any_edge are constant 0.
